// File: rtl/pmem_responder.sv
// Fixed-latency line memory standing in for physical memory below the LC-3b cache.
// Accepts one read or write per transaction and answers with a one-cycle pmem_resp.
module pmem_responder #(
    parameter int LATENCY = 8,
    parameter int LINES   = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         protocol_err
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [7:0] CNT_INIT = 8'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state_q;
    logic [7:0]         cnt_q;
    logic               is_write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [127:0]       wdata_q;
    logic [127:0]       store_q [LINES];

    logic [IDX_W-1:0]   idx_d;
    logic               unused_addr;

    // Offset bits and the aliasing high bits do not select a line.
    assign idx_d       = pmem_address[4 +: IDX_W];
    assign unused_addr = ^pmem_address;

    // NOTE: every register here, store included, uses <= so all reads in this
    // block see the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_write_q   <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            pmem_resp    <= 1'b0;
            pmem_rdata   <= '0;
            protocol_err <= 1'b0;
            // NOTE: the line store is cleared on reset, so it must be built from
            // flops rather than an SRAM macro without a clear port.
            for (int i = 0; i < LINES; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            // NOTE: defaulting the pulse low here makes pmem_resp last exactly
            // the one cycle after the edge that sets it.
            pmem_resp <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        is_write_q <= pmem_write;
                        idx_q      <= idx_d;
                        wdata_q    <= pmem_wdata;
                        if (pmem_read && pmem_write) begin
                            protocol_err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            // No BUSY phase: the access happens on the accept edge.
                            if (pmem_write) begin
                                store_q[idx_d] <= pmem_wdata;
                            end else begin
                                pmem_rdata <= store_q[idx_d];
                            end
                            pmem_resp <= 1'b1;
                            state_q   <= RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        if (is_write_q) begin
                            store_q[idx_q] <= wdata_q;
                        end else begin
                            pmem_rdata <= store_q[idx_q];
                        end
                        pmem_resp <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: two instances (LATENCY=8 and LATENCY=1)
// driven with directed and random transactions against an array-based line model.
module tb_pmem_responder;

    localparam int LAT8   = 8;
    localparam int LINES8 = 256;
    localparam int LINES1 = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;

    logic         rd8 = 1'b0, wr8 = 1'b0;
    logic [15:0]  addr8 = '0;
    logic [127:0] wd8 = '0;
    logic         resp8, err8;
    logic [127:0] rdata8;

    logic         rd1 = 1'b0, wr1 = 1'b0;
    logic [15:0]  addr1 = '0;
    logic [127:0] wd1 = '0;
    logic         resp1, err1;
    logic [127:0] rdata1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [127:0] model8 [LINES8];
    logic [127:0] model1 [LINES1];
    logic [127:0] exp_rd8, exp_rd1;

    pmem_responder #(.LATENCY(LAT8), .LINES(LINES8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .pmem_read(rd8), .pmem_write(wr8), .pmem_address(addr8), .pmem_wdata(wd8),
        .pmem_resp(resp8), .pmem_rdata(rdata8), .protocol_err(err8)
    );

    pmem_responder #(.LATENCY(1), .LINES(LINES1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1), .pmem_wdata(wd1),
        .pmem_resp(resp1), .pmem_rdata(rdata1), .protocol_err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void clear_models();
        for (int i = 0; i < LINES8; i++) model8[i] = '0;
        for (int i = 0; i < LINES1; i++) model1[i] = '0;
        exp_rd8 = '0;
        exp_rd1 = '0;
    endfunction

    // Write wins over read; a read updates the expected held rdata.
    function automatic void model_op(input bit sel, input bit wr, input logic [15:0] addr,
                                     input logic [127:0] wd);
        if (sel) begin
            if (wr) model1[addr[7:4]] = wd;
            else    exp_rd1 = model1[addr[7:4]];
        end else begin
            if (wr) model8[addr[11:4]] = wd;
            else    exp_rd8 = model8[addr[11:4]];
        end
    endfunction

    // Drives a request at a negedge (cycle 0) and waits for resp; lat=-1 on timeout.
    task automatic txn(input bit sel, input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [127:0] wd, input bit perturb,
                       output int lat, output logic [127:0] rdat, output int resp_cyc);
        @(negedge clk);
        if (sel) begin rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wd; end
        else     begin rd8 = rd; wr8 = wr; addr8 = addr; wd8 = wd; end
        lat = -1;
        rdat = 'x;
        resp_cyc = -1;
        for (int c = 1; c <= LAT8 + 20; c++) begin
            @(negedge clk);
            if (perturb && c == 2) begin
                addr8 = 16'($urandom);
                wd8 = {$urandom, $urandom, $urandom, $urandom};
            end
            if ((sel ? resp1 : resp8) === 1'b1) begin
                lat = c;
                rdat = sel ? rdata1 : rdata8;
                resp_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        rd8 = 1'b0; wr8 = 1'b0;
        rd1 = 1'b0; wr1 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({resp8, err8, rdata8} !== '0) begin
            bad++;
            $display("FAIL reset_dut8 got resp=%0b err=%0b rdata=%h want all zero", resp8, err8, rdata8);
        end
        total++;
        if ({resp1, err1, rdata1} !== '0) begin
            bad++;
            $display("FAIL reset_dut1 got resp=%0b err=%0b rdata=%h want all zero", resp1, err1, rdata1);
        end
        reset_n = 1'b1;
        clear_models();
    endtask

    task automatic test_first_read();
        int lat, rc;
        logic [127:0] rd;
        txn(0, 1, 0, 16'h0040, '0, 0, lat, rd, rc);
        model_op(0, 0, 16'h0040, '0);
        idle();
        total++;
        if (lat !== LAT8) begin bad++; $display("FAIL first_read_latency got=%0d want=%0d", lat, LAT8); end
        total++;
        if (rd !== exp_rd8) begin bad++; $display("FAIL first_read_data got=%h want=%h", rd, exp_rd8); end
        total++;
        if (resp8 !== 1'b0) begin bad++; $display("FAIL first_read_pulse_width got=%0b want=0", resp8); end
        total++;
        if (err8 !== 1'b0) begin bad++; $display("FAIL first_read_err got=%0b want=0", err8); end
    endtask

    task automatic test_write_read();
        int lat_w, lat_r, rc_w, rc_r;
        logic [127:0] rd_w, rd_r;
        logic [127:0] pat;
        pat = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        txn(0, 0, 1, 16'h1230, pat, 0, lat_w, rd_w, rc_w);
        model_op(0, 1, 16'h1230, pat);
        txn(0, 1, 0, 16'h123F, '0, 0, lat_r, rd_r, rc_r);
        model_op(0, 0, 16'h123F, '0);
        idle();
        total++;
        if (lat_w !== LAT8) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", lat_w, LAT8); end
        total++;
        if (rc_r - rc_w !== LAT8 + 1) begin
            bad++; $display("FAIL back_to_back_spacing got=%0d want=%0d", rc_r - rc_w, LAT8 + 1);
        end
        total++;
        if (rd_r !== pat) begin bad++; $display("FAIL read_after_write got=%h want=%h", rd_r, pat); end
        total++;
        if (rd_r !== exp_rd8) begin bad++; $display("FAIL read_after_write_model got=%h want=%h", rd_r, exp_rd8); end
    endtask

    task automatic test_random();
        int lat, rc;
        logic [127:0] rd, d;
        logic [15:0] a;
        bit wr;
        for (int n = 0; n < 16; n++) begin
            a = 16'($urandom);
            a[11:7] = '0;
            wr = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom, $urandom, $urandom};
            txn(0, !wr, wr, a, d, 0, lat, rd, rc);
            model_op(0, wr, a, d);
            total++;
            if (lat !== LAT8) begin bad++; $display("FAIL rand_latency n=%0d got=%0d want=%0d", n, lat, LAT8); end
            total++;
            if (rd !== exp_rd8) begin
                bad++; $display("FAIL rand_rdata n=%0d wr=%0b got=%h want=%h", n, wr, rd, exp_rd8);
            end
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        total++;
        if (err8 !== 1'b0) begin bad++; $display("FAIL rand_err got=%0b want=0", err8); end
    endtask

    task automatic test_conflict();
        int lat, rc;
        logic [127:0] rd;
        txn(0, 1, 1, 16'h0010, '1, 0, lat, rd, rc);
        model_op(0, 1, 16'h0010, '1);
        idle();
        total++;
        if (lat !== LAT8) begin bad++; $display("FAIL conflict_latency got=%0d want=%0d", lat, LAT8); end
        total++;
        if (err8 !== 1'b1) begin bad++; $display("FAIL conflict_err_set got=%0b want=1", err8); end
        txn(0, 1, 0, 16'h0010, '0, 0, lat, rd, rc);
        model_op(0, 0, 16'h0010, '0);
        idle();
        total++;
        if (rd !== exp_rd8) begin bad++; $display("FAIL conflict_write_wins got=%h want=%h", rd, exp_rd8); end
        total++;
        if (err8 !== 1'b1) begin bad++; $display("FAIL conflict_err_sticky got=%0b want=1", err8); end
    endtask

    task automatic test_alias();
        int lat_w, lat_r, rc;
        logic [127:0] rd;
        logic [127:0] pat;
        pat = {8{16'hAAAA}};
        txn(0, 0, 1, 16'h0100, pat, 1, lat_w, rd, rc);
        model_op(0, 1, 16'h0100, pat);
        idle();
        txn(0, 1, 0, 16'h1100, '0, 1, lat_r, rd, rc);
        model_op(0, 0, 16'h1100, '0);
        idle();
        total++;
        if (lat_w !== LAT8 || lat_r !== LAT8) begin
            bad++; $display("FAIL alias_latency got=%0d/%0d want=%0d", lat_w, lat_r, LAT8);
        end
        total++;
        if (rd !== exp_rd8) begin bad++; $display("FAIL alias_data got=%h want=%h", rd, exp_rd8); end
    endtask

    task automatic test_lat1();
        int lat_a, lat_b, rc_a, rc_b;
        logic [127:0] rd_a, rd_b, d;
        logic [15:0] a;
        bit wr;
        txn(1, 1, 0, 16'h0000, '0, 0, lat_a, rd_a, rc_a);
        model_op(1, 0, 16'h0000, '0);
        txn(1, 1, 0, 16'h0010, '0, 0, lat_b, rd_b, rc_b);
        model_op(1, 0, 16'h0010, '0);
        idle();
        total++;
        if (lat_a !== 1 || lat_b !== 1) begin
            bad++; $display("FAIL lat1_latency got=%0d/%0d want=1", lat_a, lat_b);
        end
        total++;
        if (rc_b - rc_a !== 2) begin bad++; $display("FAIL lat1_spacing got=%0d want=2", rc_b - rc_a); end
        for (int n = 0; n < 12; n++) begin
            a = 16'($urandom);
            wr = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom, $urandom, $urandom};
            txn(1, !wr, wr, a, d, 0, lat_a, rd_a, rc_a);
            model_op(1, wr, a, d);
            total++;
            if (lat_a !== 1) begin bad++; $display("FAIL lat1_rand_latency n=%0d got=%0d want=1", n, lat_a); end
            total++;
            if (rd_a !== exp_rd1) begin
                bad++; $display("FAIL lat1_rand_rdata n=%0d got=%h want=%h", n, rd_a, exp_rd1);
            end
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
    endtask

    task automatic test_reset_abort();
        int lat, rc;
        logic [127:0] rd;
        bit saw;
        saw = 1'b0;
        @(negedge clk);
        wr8 = 1'b1; addr8 = 16'h0200; wd8 = {4{32'hDEAD_BEEF}};
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (resp8 === 1'b1) saw = 1'b1;
            if (c == 4) reset_n = 1'b0;
            if (c == 5) begin reset_n = 1'b1; wr8 = 1'b0; end
        end
        clear_models();
        total++;
        if (saw !== 1'b0) begin bad++; $display("FAIL abort_no_resp got=1 want=0"); end
        total++;
        if (err8 !== 1'b0 || rdata8 !== '0) begin
            bad++; $display("FAIL abort_reset_outputs got err=%0b rdata=%h want 0", err8, rdata8);
        end
        txn(0, 1, 0, 16'h0200, '0, 0, lat, rd, rc);
        model_op(0, 0, 16'h0200, '0);
        idle();
        total++;
        if (lat !== LAT8) begin bad++; $display("FAIL abort_read_latency got=%0d want=%0d", lat, LAT8); end
        total++;
        if (rd !== exp_rd8) begin bad++; $display("FAIL abort_no_store_write got=%h want=%h", rd, exp_rd8); end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write_read();
        test_random();
        test_conflict();
        test_alias();
        test_lat1();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
